// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Both flops clear to 0 on reset so a held-high input is never seen
// as asserted until two clock edges after reset release.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_toggle_cnt.sv
// GPIO loopback responder: once the synchronized trigger has been high
// for CntMax clock cycles, drive a registered response high until the
// trigger drops.
//
// state | meaning
// IDLE  | trigger low, response low, counter cleared
// COUNT | trigger high, counting qualifying cycles
// DONE  | trigger held long enough, response high until trigger drops
module gpio_toggle_cnt #(
  parameter logic [31:0] CntMax = 32'd16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic gpio_i,
  output logic gpio_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        gpio_q, gpio_d;
  logic        gpio_s;

  sync_2ff u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (gpio_i),
    .q_o    (gpio_s)
  );

  // State, counter and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      gpio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gpio_q  <= gpio_d;
    end
  end

  // Next-state logic; the response is decided here so it rises on the
  // same edge as the DONE transition and stays purely registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gpio_d  = gpio_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = 32'd0;
        gpio_d = 1'b0;
        if (gpio_s) begin
          if (CntMax == 32'd1) begin
            state_d = DONE;
            gpio_d  = 1'b1;
          end else begin
            state_d = COUNT;
            cnt_d   = 32'd1;
          end
        end
      end
      COUNT: begin
        if (!gpio_s) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
          gpio_d  = 1'b0;
        end else if (cnt_q == CntMax - 32'd1) begin
          // Counter stops here, so it never needs to wrap.
          state_d = DONE;
          gpio_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        gpio_d = 1'b1;
        if (!gpio_s) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
          gpio_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
        gpio_d  = 1'b0;
      end
    endcase
  end

  assign gpio_o = gpio_q;

endmodule

// File: tb/tb_gpio_toggle_cnt.sv
// Bench for gpio_toggle_cnt: a CntMax=16 and a CntMax=1 instance share
// the trigger and reset; both are compared every cycle against a
// run-length reference model, plus directed edge-count checks.
module tb_gpio_toggle_cnt;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic gpio_i = 1'b0;
  logic gpio16_o;
  logic gpio1_o;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_toggle_cnt #(.CntMax(32'd16)) u_dut16 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .gpio_i (gpio_i),
    .gpio_o (gpio16_o)
  );

  gpio_toggle_cnt #(.CntMax(32'd1)) u_dut1 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .gpio_i (gpio_i),
    .gpio_o (gpio1_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the FSM sees the trigger sampled two edges earlier;
  // the response is high once that delayed trigger has been 1 on at
  // least CntMax consecutive edges.
  bit          hist[$];
  int unsigned run = 0;

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      hist.delete();
      run = 0;
    end else begin
      bit seen;
      hist.push_back(gpio_i);
      seen = (hist.size() >= 3) ? hist[hist.size()-3] : 1'b0;
      if (hist.size() > 4) void'(hist.pop_front());
      run = seen ? run + 1 : 0;
    end
  end

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: wait for the falling edge, compare both instances to the model.
  task automatic tick();
    @(negedge clk_i);
    check_eq("model16", gpio16_o, rst_ni && (run >= 16));
    check_eq("model1",  gpio1_o,  rst_ni && (run >= 1));
  endtask

  // Assert reset asynchronously between edges and check the immediate effect.
  task automatic async_reset(input int dly, input string tag);
    #(dly);
    rst_ni = 1'b0;
    #1;
    check_eq({tag, "_o16"}, gpio16_o, 1'b0);
    check_eq({tag, "_o1"},  gpio1_o,  1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // Count edges from now with the trigger already set; check rise at edge 18.
  task automatic expect_rise18(input string tag);
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 17) check_eq({tag, "_e17"}, gpio16_o, 1'b0);
      if (e == 18) check_eq({tag, "_e18"}, gpio16_o, 1'b1);
    end
  endtask

  initial begin
    // Reset held with trigger high: response must stay low.
    gpio_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rst_hold", gpio16_o, 1'b0);
    end
    rst_ni = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 2)  check_eq("cm1_e2", gpio1_o, 1'b0);
      if (e == 3)  check_eq("cm1_e3", gpio1_o, 1'b1);
      if (e == 17) check_eq("rel_e17", gpio16_o, 1'b0);
      if (e == 18) check_eq("rel_e18", gpio16_o, 1'b1);
    end

    // Drop: response falls on the third edge.
    gpio_i = 1'b0;
    tick(); check_eq("drop_e1", gpio16_o, 1'b1);
    tick(); check_eq("drop_e2", gpio16_o, 1'b1);
    tick(); check_eq("drop_e3", gpio16_o, 1'b0);
    repeat (3) tick();

    // Nominal rise from idle.
    gpio_i = 1'b1;
    expect_rise18("nom");
    gpio_i = 1'b0;
    repeat (5) tick();

    // Short pulse never asserts; a following long pulse does.
    gpio_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("short", gpio16_o, 1'b0);
    end
    gpio_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("short_tail", gpio16_o, 1'b0);
    end
    gpio_i = 1'b1;
    expect_rise18("long");

    // Retrigger: low for two cycles, response drops then reasserts.
    gpio_i = 1'b0;
    tick();
    tick();
    gpio_i = 1'b1;
    tick();
    check_eq("retrig_drop", gpio16_o, 1'b0);
    for (int e = 2; e <= 20; e++) begin
      tick();
      if (e == 17) check_eq("retrig_e17", gpio16_o, 1'b0);
      if (e == 18) check_eq("retrig_e18", gpio16_o, 1'b1);
    end

    // Reset mid-count (counter at 8 after ten edges) and in DONE.
    gpio_i = 1'b0;
    repeat (4) tick();
    gpio_i = 1'b1;
    repeat (10) tick();
    async_reset(2, "rst_count");
    expect_rise18("after_rst_count");
    async_reset(2, "rst_done");
    expect_rise18("after_rst_done");

    // Randomized levels and hold times, with occasional async resets.
    for (int it = 0; it < 300; it++) begin
      gpio_i = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 24)) tick();
      if ($urandom_range(0, 19) == 0) async_reset(int'($urandom_range(1, 3)), "rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
